// File: rtl/sha256_pkg.sv
// Shared constants and encodings for the SHA-256 message block server.
package sha256_pkg;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam logic [31:0] LEN_HDR  = 32'h0000_0280;
    localparam logic [31:0] LEN_DIG  = 32'h0000_0100;

    localparam int HDR_WORDS = 19;
    localparam int NONCE_IDX = 19;

    typedef enum logic [1:0] {
        BLK_HDR0 = 2'd0,
        BLK_HDR1 = 2'd1,
        BLK_DIG  = 2'd2,
        BLK_NONE = 2'd3
    } blk_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RDY  = 2'd2
    } srv_state_e;

endpackage

// File: rtl/sha256_block_mux.sv
// Combinational selection of one padded message word for the chosen block.
module sha256_block_mux
    import sha256_pkg::*;
(
    input  logic [1:0]   blk_sel,
    input  logic [3:0]   addr,
    input  logic [31:0]  hdr [HDR_WORDS],
    input  logic [31:0]  nonce,
    input  logic [255:0] dig,
    output logic [31:0]  word
);

    always_comb begin
        word = '0;
        case (blk_sel)
            BLK_HDR0: word = hdr[{1'b0, addr}];
            BLK_HDR1: begin
                case (addr)
                    4'd0:    word = hdr[16];
                    4'd1:    word = hdr[17];
                    4'd2:    word = hdr[18];
                    4'd3:    word = nonce;
                    4'd4:    word = PAD_WORD;
                    4'd15:   word = LEN_HDR;
                    default: word = '0;
                endcase
            end
            BLK_DIG: begin
                // Digest word 0 sits in the top 32 bits, so index from the MSB end.
                if (!addr[3])
                    word = dig[{~addr[2:0], 5'd0} +: 32];
                else if (addr == 4'd8)
                    word = PAD_WORD;
                else if (addr == 4'd15)
                    word = LEN_DIG;
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/sha256_block_server.sv
// Message-word fetch responder: header/nonce/digest storage plus the rq/rdy handshake.
module sha256_block_server
    import sha256_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hdr_we,
    input  logic [4:0]   hdr_waddr,
    input  logic [31:0]  hdr_wdata,
    input  logic         nonce_inc,
    output logic [31:0]  nonce,
    input  logic         dig_load,
    input  logic [255:0] dig_in,
    input  logic [1:0]   blk_sel,
    input  logic         rq,
    input  logic [3:0]   addr,
    output logic         rdy,
    output logic [31:0]  data,
    output logic         busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    srv_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic [31:0]  hdr_q [HDR_WORDS];
    logic [31:0]  hdr_d [HDR_WORDS];
    logic [31:0]  nonce_q, nonce_d;
    logic [255:0] dig_q, dig_d;
    logic [31:0]  mux_word;

    sha256_block_mux u_mux (
        .blk_sel (blk_sel),
        .addr    (addr_q),
        .hdr     (hdr_q),
        .nonce   (nonce_q),
        .dig     (dig_q),
        .word    (mux_word)
    );

    // A header write to the nonce slot overrides a simultaneous increment.
    always_comb begin
        hdr_d   = hdr_q;
        nonce_d = nonce_q;
        dig_d   = dig_q;
        if (nonce_inc)
            nonce_d = nonce_q + 32'd1;
        if (hdr_we) begin
            if (hdr_waddr < 5'(HDR_WORDS))
                hdr_d[hdr_waddr] = hdr_wdata;
            else if (hdr_waddr == 5'(NONCE_IDX))
                nonce_d = hdr_wdata;
        end
        if (dig_load)
            dig_d = dig_in;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (rq) begin
                    state_d = S_WAIT;
                    addr_d  = addr;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RDY;
                    data_d  = mux_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // Always return to idle so a still-high rq is not re-accepted here.
            S_RDY:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            nonce_q <= '0;
            dig_q   <= '0;
            for (int i = 0; i < HDR_WORDS; i++)
                hdr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            nonce_q <= nonce_d;
            dig_q   <= dig_d;
            hdr_q   <= hdr_d;
        end
    end

    assign rdy   = (state_q == S_RDY);
    assign busy  = (state_q != S_IDLE);
    assign data  = data_q;
    assign nonce = nonce_q;

endmodule

// File: tb/tb_sha256_block_server.sv
// Self-checking bench: three server instances (LATENCY 1, 4, 3) against a block-level model.
module tb_sha256_block_server;

    logic         clk;
    logic         rst_n;
    logic         hdr_we;
    logic [4:0]   hdr_waddr;
    logic [31:0]  hdr_wdata;
    logic         nonce_inc;
    logic         dig_load;
    logic [255:0] dig_in;
    logic [1:0]   blk_sel;
    logic         rq      [3];
    logic [3:0]   addr    [3];
    logic         rdy_o   [3];
    logic [31:0]  data_o  [3];
    logic         busy_o  [3];
    logic [31:0]  nonce_o [3];

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hdr [19];
    logic [31:0] m_nonce;
    logic [31:0] m_dig [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sha256_block_server #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hdr_we(hdr_we), .hdr_waddr(hdr_waddr), .hdr_wdata(hdr_wdata),
        .nonce_inc(nonce_inc), .nonce(nonce_o[0]), .dig_load(dig_load), .dig_in(dig_in),
        .blk_sel(blk_sel), .rq(rq[0]), .addr(addr[0]), .rdy(rdy_o[0]), .data(data_o[0]), .busy(busy_o[0])
    );

    sha256_block_server #(.LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .hdr_we(hdr_we), .hdr_waddr(hdr_waddr), .hdr_wdata(hdr_wdata),
        .nonce_inc(nonce_inc), .nonce(nonce_o[1]), .dig_load(dig_load), .dig_in(dig_in),
        .blk_sel(blk_sel), .rq(rq[1]), .addr(addr[1]), .rdy(rdy_o[1]), .data(data_o[1]), .busy(busy_o[1])
    );

    sha256_block_server #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .hdr_we(hdr_we), .hdr_waddr(hdr_waddr), .hdr_wdata(hdr_wdata),
        .nonce_inc(nonce_inc), .nonce(nonce_o[2]), .dig_load(dig_load), .dig_in(dig_in),
        .blk_sel(blk_sel), .rq(rq[2]), .addr(addr[2]), .rdy(rdy_o[2]), .data(data_o[2]), .busy(busy_o[2])
    );

    // Build the whole 16-word padded block from the message layout, then pick one word.
    function automatic logic [31:0] model_word(input int blk, input int a);
        logic [31:0] w [16];
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        case (blk)
            0: for (int i = 0; i < 16; i++) w[i] = m_hdr[i];
            1: begin
                for (int i = 0; i < 3; i++) w[i] = m_hdr[16 + i];
                w[3]  = m_nonce;
                w[4]  = 32'h8000_0000;
                w[15] = 32'd640;
            end
            2: begin
                for (int i = 0; i < 8; i++) w[i] = m_dig[i];
                w[8]  = 32'h8000_0000;
                w[15] = 32'd256;
            end
            default: ;
        endcase
        return w[a];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic writeHdr(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        hdr_we = 1'b1; hdr_waddr = idx; hdr_wdata = val;
        @(posedge clk); #1;
        hdr_we = 1'b0;
        if (idx < 5'd19) m_hdr[idx] = val;
        else if (idx == 5'd19) m_nonce = val;
    endtask

    task automatic pulseNonceInc();
        @(negedge clk);
        nonce_inc = 1'b1;
        @(posedge clk); #1;
        nonce_inc = 1'b0;
        m_nonce = m_nonce + 32'd1;
    endtask

    task automatic loadDigest(input logic [255:0] v);
        @(negedge clk);
        dig_load = 1'b1; dig_in = v;
        @(posedge clk); #1;
        dig_load = 1'b0;
        for (int i = 0; i < 8; i++) m_dig[i] = v[255 - 32*i -: 32];
    endtask

    // One complete fetch: accept, wait for rdy, check word, check the pulse ends cleanly.
    task automatic applyStimulus(input int which, input logic [3:0] a, input int lat);
        int edges;
        bit got;
        logic [31:0] exp;
        @(negedge clk);
        rq[which] = 1'b1; addr[which] = a;
        @(posedge clk); #1;
        checkOutput("busy_after_accept", 32'(busy_o[which]), 32'd1);
        edges = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (rdy_o[which]) got = 1'b1;
        end
        checkOutput("rdy_seen", 32'(got), 32'd1);
        checkOutput("latency", 32'(edges), 32'(lat));
        exp = model_word(int'(blk_sel), int'(a));
        checkOutput("data", data_o[which], exp);
        @(posedge clk); #1;
        rq[which] = 1'b0;
        checkOutput("rdy_pulse_end", 32'(rdy_o[which]), 32'd0);
        checkOutput("busy_clear", 32'(busy_o[which]), 32'd0);
        @(posedge clk); #1;
        checkOutput("no_reaccept", 32'(busy_o[which] | rdy_o[which]), 32'd0);
        checkOutput("data_hold", data_o[which], exp);
    endtask

    function automatic int lat_of(input int which);
        return (which == 0) ? 1 : (which == 1) ? 4 : 3;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] old_nonce;
        logic [255:0] rd;
        int w;

        rst_n = 1'b0; hdr_we = 1'b0; hdr_waddr = '0; hdr_wdata = '0;
        nonce_inc = 1'b0; dig_load = 1'b0; dig_in = '0; blk_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin rq[i] = 1'b0; addr[i] = '0; end
        for (int i = 0; i < 19; i++) m_hdr[i] = '0;
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
        m_nonce = '0;

        #12;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_rdy", 32'(rdy_o[i]), 32'd0);
            checkOutput("reset_busy", 32'(busy_o[i]), 32'd0);
            checkOutput("reset_data", data_o[i], 32'd0);
            checkOutput("reset_nonce", nonce_o[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] header blocks with fixed pattern");
        for (int n = 0; n < 19; n++) writeHdr(5'(n), 32'h0100_0000 + 32'(n));
        writeHdr(5'd19, 32'h1234_5678);
        checkOutput("nonce_write", nonce_o[0], 32'h1234_5678);
        blk_sel = 2'd0;
        for (int a = 0; a < 16; a++) applyStimulus(0, 4'(a), 1);
        blk_sel = 2'd1;
        for (int a = 0; a < 16; a++) applyStimulus(0, 4'(a), 1);

        $display("[TB] digest block");
        loadDigest({32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
        blk_sel = 2'd2;
        for (int a = 0; a < 16; a++) applyStimulus(0, 4'(a), 1);

        $display("[TB] randomized fetches and updates");
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: writeHdr(5'($urandom_range(0, 31)), $urandom);
                1: pulseNonceInc();
                2: begin
                    rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    loadDigest(rd);
                end
                default: ;
            endcase
            blk_sel = 2'($urandom_range(0, 3));
            w = int'($urandom_range(0, 2));
            applyStimulus(w, 4'($urandom_range(0, 15)), lat_of(w));
        end

        $display("[TB] nonce increment on the rdy-setting edge");
        blk_sel = 2'd1;
        old_nonce = m_nonce;
        @(negedge clk);
        rq[1] = 1'b1; addr[1] = 4'd3;
        @(posedge clk); #1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            checkOutput("lat4_wait_rdy", 32'(rdy_o[1]), 32'd0);
        end
        @(negedge clk);
        nonce_inc = 1'b1;
        @(posedge clk); #1;
        nonce_inc = 1'b0;
        m_nonce = m_nonce + 32'd1;
        checkOutput("lat4_rdy", 32'(rdy_o[1]), 32'd1);
        checkOutput("old_nonce_served", data_o[1], old_nonce);
        checkOutput("nonce_incremented", nonce_o[1], m_nonce);
        @(posedge clk); #1;
        rq[1] = 1'b0;
        checkOutput("lat4_pulse_end", 32'(rdy_o[1]), 32'd0);

        $display("[TB] nonce write beats increment, then wrap");
        @(negedge clk);
        hdr_we = 1'b1; hdr_waddr = 5'd19; hdr_wdata = 32'hFFFF_FFFF; nonce_inc = 1'b1;
        @(posedge clk); #1;
        hdr_we = 1'b0; nonce_inc = 1'b0;
        m_nonce = 32'hFFFF_FFFF;
        checkOutput("write_wins", nonce_o[0], m_nonce);
        pulseNonceInc();
        checkOutput("nonce_wrap", nonce_o[0], m_nonce);
        applyStimulus(0, 4'd3, 1);

        $display("[TB] reset during a request");
        blk_sel = 2'd1;
        applyStimulus(2, 4'd4, 3);
        @(negedge clk);
        rq[2] = 1'b1; addr[2] = 4'd4;
        @(posedge clk); #1;
        checkOutput("busy_before_reset", 32'(busy_o[2]), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_rdy", 32'(rdy_o[2]), 32'd0);
        checkOutput("reset_mid_busy", 32'(busy_o[2]), 32'd0);
        checkOutput("reset_mid_data", data_o[2], 32'd0);
        rq[2] = 1'b0;
        for (int i = 0; i < 19; i++) m_hdr[i] = '0;
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
        m_nonce = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            checkOutput("no_phantom_rdy", 32'(rdy_o[2] | busy_o[2]), 32'd0);
        end
        blk_sel = 2'd0;
        applyStimulus(2, 4'd5, 3);
        blk_sel = 2'd1;
        applyStimulus(2, 4'd3, 3);
        applyStimulus(2, 4'd15, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
